f_align_ctrl: RTL and testbench

//  Multi-cycle operand-alignment sequencer for the FP adder. Accepts two IEEE-754 binary32

---
 rtl/f_align_ctrl_if.sv | 40 ++++
 rtl/f_align_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_f_align_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/f_align_ctrl_if.sv
// ---------------------------------------------------------------------------
// f_align_ctrl_if
// Bus bundle for the FP-adder operand-alignment sequencer.
//   Operand side : in_valid / in_ready handshake, a, b (binary32)
//   Result side  : out_valid / out_ready handshake, big_sign, small_sign,
//                  big_exp, big_mant, small_mant, swapped, special
// Modports:
//   master - the producer/consumer around the block (drives operands,
//            accepts results)
//   slave  - the alignment block itself
// ---------------------------------------------------------------------------
interface f_align_ctrl_if #(
  parameter int MANT_W = 27
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic              big_sign;
  logic              small_sign;
  logic [7:0]        big_exp;
  logic [MANT_W-1:0] big_mant;
  logic [MANT_W-1:0] small_mant;
  logic              swapped;
  logic              special;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, big_sign, small_sign, big_exp,
           big_mant, small_mant, swapped, special
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, big_sign, small_sign, big_exp,
           big_mant, small_mant, swapped, special
  );
endinterface

// File: rtl/f_align_ctrl.sv
// ---------------------------------------------------------------------------
// f_align_ctrl
// Multi-cycle operand-alignment sequencer for the FP adder. Takes two
// binary32 operands, picks the one with the larger effective exponent as
// "big", then right-shifts the small mantissa up to STEP bits per cycle,
// folding every bit shifted out into a sticky LSB. The aligned pair and the
// common exponent are then offered on the result handshake.
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of f_align_ctrl_if:
//            in_valid/in_ready, a, b           operand handshake
//            out_valid/out_ready               result handshake
//            big_sign, small_sign, big_exp, big_mant, small_mant,
//            swapped (B was big), special (an exponent was 8'hFF)
// ---------------------------------------------------------------------------
module f_align_ctrl #(
  parameter int STEP   = 4,
  parameter int MANT_W = 27
) (
  input  logic           clk,
  input  logic           reset,
  f_align_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIFF  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] STEP_C = 9'(STEP);
  localparam logic [8:0] MANT_C = 9'(MANT_W);

  state_t            state_r;
  state_t            state_n;

  logic [31:0]       a_r;
  logic [31:0]       b_r;
  logic [8:0]        rem_r;
  logic              out_valid_r;
  logic              big_sign_r;
  logic              small_sign_r;
  logic [7:0]        big_exp_r;
  logic [MANT_W-1:0] big_mant_r;
  logic [MANT_W-1:0] small_mant_r;
  logic              swapped_r;
  logic              special_r;

  logic              in_ready_s;
  logic [7:0]        ea_s;
  logic [7:0]        eb_s;
  logic [MANT_W-1:0] ma_s;
  logic [MANT_W-1:0] mb_s;
  logic [8:0]        a_minus_b_s;
  logic [8:0]        b_minus_a_s;
  logic              alessb_s;
  logic [8:0]        d_s;
  logic              special_s;
  logic [MANT_W-1:0] small_load_s;
  logic [MANT_W-1:0] big_load_s;
  logic [8:0]        k_s;
  logic [MANT_W-1:0] lost_mask_s;
  logic [MANT_W-1:0] shifted_s;
  logic              sticky_s;
  logic [MANT_W-1:0] small_next_s;

  assign in_ready_s = (state_r == IDLE) & ~reset;

  // Decode captured operands: effective exponents, mantissas, difference and swap.
  always_comb begin
    ea_s = a_r[30:23];
    eb_s = b_r[30:23];
    // Denormals/zero behave as exponent 1 with no hidden bit.
    if (a_r[30:23] == 8'd0) begin
      ea_s = 8'd1;
      ma_s = {1'b0, a_r[22:0], 3'b000};
    end else begin
      ma_s = {1'b1, a_r[22:0], 3'b000};
    end
    if (b_r[30:23] == 8'd0) begin
      eb_s = 8'd1;
      mb_s = {1'b0, b_r[22:0], 3'b000};
    end else begin
      mb_s = {1'b1, b_r[22:0], 3'b000};
    end
    // Both differences in parallel; the borrow bit of A-B selects direction.
    a_minus_b_s = {1'b0, ea_s} + ~{1'b0, eb_s} + 9'd1;
    b_minus_a_s = {1'b0, eb_s} + ~{1'b0, ea_s} + 9'd1;
    alessb_s    = a_minus_b_s[8];
    special_s   = (a_r[30:23] == 8'hFF) | (b_r[30:23] == 8'hFF);
    if (alessb_s) begin
      d_s          = b_minus_a_s;
      big_load_s   = mb_s;
      small_load_s = ma_s;
    end else begin
      d_s          = a_minus_b_s;
      big_load_s   = ma_s;
      small_load_s = mb_s;
    end
  end

  // One shift step: move by min(STEP, rem) and OR the dropped bits into bit 0.
  always_comb begin
    if (rem_r < STEP_C) begin
      k_s = rem_r;
    end else begin
      k_s = STEP_C;
    end
    lost_mask_s  = ~({MANT_W{1'b1}} << k_s);
    shifted_s    = small_mant_r >> k_s;
    sticky_s     = |(small_mant_r & lost_mask_s);
    small_next_s = {shifted_s[MANT_W-1:1], shifted_s[0] | sticky_s};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_s) begin
          state_n = DIFF;
        end else begin
          state_n = IDLE;
        end
      end
      DIFF: begin
        if (special_s || (d_s >= MANT_C) || (d_s == 9'd0)) begin
          state_n = DONE;
        end else begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // The step that consumes the last remaining bits ends the shift.
        if (rem_r <= STEP_C) begin
          state_n = DONE;
        end else begin
          state_n = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, alignment datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      rem_r        <= 9'd0;
      out_valid_r  <= 1'b0;
      big_sign_r   <= 1'b0;
      small_sign_r <= 1'b0;
      big_exp_r    <= 8'd0;
      big_mant_r   <= {MANT_W{1'b0}};
      small_mant_r <= {MANT_W{1'b0}};
      swapped_r    <= 1'b0;
      special_r    <= 1'b0;
    end else begin
      out_valid_r <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_s) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        DIFF: begin
          rem_r      <= d_s;
          swapped_r  <= alessb_s;
          special_r  <= special_s;
          big_mant_r <= big_load_s;
          if (alessb_s) begin
            big_sign_r   <= b_r[31];
            small_sign_r <= a_r[31];
            big_exp_r    <= eb_s;
          end else begin
            big_sign_r   <= a_r[31];
            small_sign_r <= b_r[31];
            big_exp_r    <= ea_s;
          end
          // Special operands pass through unshifted; huge differences collapse to sticky.
          if (!special_s && (d_s >= MANT_C)) begin
            small_mant_r <= {{(MANT_W-1){1'b0}}, |small_load_s};
          end else begin
            small_mant_r <= small_load_s;
          end
        end
        SHIFT: begin
          small_mant_r <= small_next_s;
          rem_r        <= rem_r - k_s;
        end
        DONE: begin
          rem_r <= rem_r;
        end
        default: begin
          rem_r <= 9'd0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.big_sign   = big_sign_r;
  assign bus.small_sign = small_sign_r;
  assign bus.big_exp    = big_exp_r;
  assign bus.big_mant   = big_mant_r;
  assign bus.small_mant = small_mant_r;
  assign bus.swapped    = swapped_r;
  assign bus.special    = special_r;

endmodule

// File: tb/tb_f_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_f_align_ctrl
// Directed bench for f_align_ctrl with STEP=4: hand-computed alignment
// results, latency counts, output hold under back-pressure, and reset
// during a shift.
// ---------------------------------------------------------------------------
module tb_f_align_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   seen;

  always #5 clk = ~clk;

  f_align_ctrl_if #(.MANT_W(27)) bus ();

  f_align_ctrl #(.STEP(4), .MANT_W(27)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, return edges from acceptance to out_valid.
  task automatic run_op(input string t, input logic [31:0] ta, input logic [31:0] tb_v,
                        output int n);
    @(negedge clk);
    chk({t, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h12345678;
    n = 0;
    while ((bus.out_valid !== 1'b1) && (n < 100)) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic exp_res(input string t, input int n, input int e_lat, input logic [7:0] be,
                         input logic [26:0] bm, input logic [26:0] sm, input logic sw,
                         input logic sp, input logic bs, input logic ss);
    chk({t, ":latency"},    32'(n),              32'(e_lat));
    chk({t, ":out_valid"},  32'(bus.out_valid),  32'd1);
    chk({t, ":in_ready"},   32'(bus.in_ready),   32'd0);
    chk({t, ":big_exp"},    32'(bus.big_exp),    32'(be));
    chk({t, ":big_mant"},   32'(bus.big_mant),   32'(bm));
    chk({t, ":small_mant"}, 32'(bus.small_mant), 32'(sm));
    chk({t, ":swapped"},    32'(bus.swapped),    32'(sw));
    chk({t, ":special"},    32'(bus.special),    32'(sp));
    chk({t, ":big_sign"},   32'(bus.big_sign),   32'(bs));
    chk({t, ":small_sign"}, 32'(bus.small_sign), 32'(ss));
  endtask

  task automatic drain(input string t);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({t, ":drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({t, ":drain_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:in_ready",   32'(bus.in_ready),   32'd0);
    chk("rst:out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst:big_exp",    32'(bus.big_exp),    32'd0);
    chk("rst:big_mant",   32'(bus.big_mant),   32'd0);
    chk("rst:small_mant", 32'(bus.small_mant), 32'd0);
    chk("rst:swapped",    32'(bus.swapped),    32'd0);
    chk("rst:special",    32'(bus.special),    32'd0);
    chk("rst:signs",      32'({bus.big_sign, bus.small_sign}), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst:in_ready_rel", 32'(bus.in_ready), 32'd1);

    // d=1, B larger
    run_op("op1", 32'h3F800000, 32'h40000000, lat);
    exp_res("op1", lat, 2, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("op1");

    // equal exponents, no swap
    run_op("op2", 32'h40400000, 32'h40000000, lat);
    exp_res("op2", lat, 1, 8'h80, 27'h6000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op2");

    // d=24 with sticky, then back-pressure hold with in_valid asserted
    run_op("op3", 32'h4B800000, 32'h3F800001, lat);
    exp_res("op3", lat, 7, 8'h97, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.a        = 32'h40000000;
    bus.b        = 32'h3F800000;
    repeat (10) @(posedge clk);
    #1;
    exp_res("op3hold", 7, 7, 8'h97, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain("op3");

    // d=126 saturates to sticky only
    run_op("op4", 32'h7E800000, 32'h3F800000, lat);
    exp_res("op4", lat, 1, 8'hFD, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op4");

    // denormal A vs smallest normal B: both effective exponent 1
    run_op("op5", 32'h00000001, 32'h00800000, lat);
    exp_res("op5", lat, 1, 8'h01, 27'h0000008, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op5");

    // signs follow the swap decision
    run_op("op6", 32'hC0000000, 32'h3F800000, lat);
    exp_res("op6", lat, 2, 8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("op6");

    // d=4: exactly one full step
    run_op("op7", 32'h41800000, 32'h3F800000, lat);
    exp_res("op7", lat, 2, 8'h83, 27'h4000000, 27'h0400000, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op7");

    // d=26: last shifted case, seven steps
    run_op("op8", 32'h4C800000, 32'h3F800000, lat);
    exp_res("op8", lat, 8, 8'h99, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op8");

    // d=27: first saturated case
    run_op("op9", 32'h4D000000, 32'h3F800000, lat);
    exp_res("op9", lat, 1, 8'h9A, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("op9");

    // special on A: no alignment
    run_op("op10", 32'h7F800000, 32'h3F800000, lat);
    exp_res("op10", lat, 1, 8'hFF, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("op10");

    // special on B (negative infinity), swapped
    run_op("op11", 32'h3F800000, 32'hFF800000, lat);
    exp_res("op11", lat, 1, 8'hFF, 27'h4000000, 27'h4000000, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("op11");

    // reset while shifting discards the operation
    @(negedge clk);
    bus.a        = 32'h4B800000;
    bus.b        = 32'h3F800001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid:out_valid",  32'(bus.out_valid),  32'd0);
    chk("rstmid:in_ready",   32'(bus.in_ready),   32'd0);
    chk("rstmid:big_exp",    32'(bus.big_exp),    32'd0);
    chk("rstmid:small_mant", 32'(bus.small_mant), 32'd0);
    chk("rstmid:swapped",    32'(bus.swapped),    32'd0);
    reset = 1'b0;
    seen  = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("rstmid:no_valid", 32'(seen), 32'd0);

    // recovery after reset
    run_op("op12", 32'h3F800000, 32'h40000000, lat);
    exp_res("op12", lat, 2, 8'h80, 27'h4000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("op12");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
